// File: rtl/ps2_pkg.sv
// ps2_pkg
// Shared constants and types for the PS/2 key decoder.
//   PS2_BREAK / PS2_EXT : prefix bytes that modify the next key code
//   PS2_IGN_*           : keyboard status/ack bytes that never name a key
//   rx_state_t          : frame receiver FSM states
//   is_ignored()        : true for bytes that must not touch key state
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK  = 8'hF0;
    localparam logic [7:0] PS2_EXT    = 8'hE0;

    localparam logic [7:0] PS2_IGN_00 = 8'h00;  // key detection error
    localparam logic [7:0] PS2_IGN_AA = 8'hAA;  // self-test passed
    localparam logic [7:0] PS2_IGN_EE = 8'hEE;  // echo
    localparam logic [7:0] PS2_IGN_FA = 8'hFA;  // acknowledge
    localparam logic [7:0] PS2_IGN_FE = 8'hFE;  // resend request
    localparam logic [7:0] PS2_IGN_FF = 8'hFF;  // buffer overrun

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    function automatic logic is_ignored(input logic [7:0] b);
        return (b == PS2_IGN_00) || (b == PS2_IGN_AA) || (b == PS2_IGN_EE) ||
               (b == PS2_IGN_FA) || (b == PS2_IGN_FE) || (b == PS2_IGN_FF);
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx
// Conditions the asynchronous PS/2 lines and deframes 11-bit device-to-host
// frames (start, 8 data LSB first, odd parity, stop).
// Ports:
//   i_clk, i_rst  : system clock, synchronous active-high reset
//   i_ps2_clk     : PS/2 clock line (asynchronous, idle high)
//   i_ps2_data    : PS/2 data line (asynchronous, idle high)
//   o_byte        : received data byte, valid while o_strobe is high
//   o_strobe      : high in the fall-event cycle that completes a good frame
//   o_err         : high in the cycle a parity/stop error or timeout is found
// o_strobe/o_err are decoded from the fall-event cycle itself so the parent
// can register every visible output one cycle after that event.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic [7:0] o_byte,
    output logic       o_strobe,
    output logic       o_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    // r_to_cnt is 0 in the first cycle after a fall event. The timeout fires
    // in the cycle where the count since the fall event steps to
    // TIMEOUT_CYCLES-1, so the registered error lands TIMEOUT_CYCLES-1 cycles
    // after the fall event.
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 3);

    // Input conditioning
    logic                  r_clk_s1;
    logic                  r_clk_s2;
    logic                  r_data_s1;
    logic                  r_data_s2;
    logic [FILTER_LEN-1:0] r_hist;
    logic                  r_filt;

    // Frame FSM
    rx_state_t             r_state;
    logic [2:0]            r_bit_cnt;
    logic [7:0]            r_shift;
    logic                  r_par_ok;
    logic [CNT_W-1:0]      r_to_cnt;

    logic w_all0;
    logic w_all1;
    logic w_fall;
    logic w_stop_cycle;
    logic w_timeout;

    assign w_all0 = (r_hist == '0);
    assign w_all1 = (r_hist == '1);
    // The filtered level is about to drop: this cycle is the fall event.
    assign w_fall = r_filt & w_all0;

    assign w_stop_cycle = w_fall && (r_state == STOP);
    // A fall event always wins over a timeout in the same cycle.
    assign w_timeout    = (r_state != IDLE) && !w_fall && (r_to_cnt == TO_LAST);

    assign o_byte   = r_shift;
    assign o_strobe = w_stop_cycle && r_data_s2 && r_par_ok;
    assign o_err    = (w_stop_cycle && !(r_data_s2 && r_par_ok)) || w_timeout;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clk_s1  <= 1'b1;
            r_clk_s2  <= 1'b1;
            r_data_s1 <= 1'b1;
            r_data_s2 <= 1'b1;
            r_hist    <= '1;
            r_filt    <= 1'b1;
        end else begin
            r_clk_s1  <= i_ps2_clk;
            r_clk_s2  <= r_clk_s1;
            r_data_s1 <= i_ps2_data;
            r_data_s2 <= r_data_s1;
            r_hist    <= {r_hist[FILTER_LEN-2:0], r_clk_s2};
            // Hysteresis: mixed history holds the previous level.
            if (w_all0) begin
                r_filt <= 1'b0;
            end else if (w_all1) begin
                r_filt <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_bit_cnt <= 3'd0;
            r_shift   <= 8'h00;
            r_par_ok  <= 1'b0;
            r_to_cnt  <= '0;
        end else begin
            if (w_fall || (r_state == IDLE)) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + CNT_W'(1);
            end

            if (w_fall) begin
                case (r_state)
                    IDLE: begin
                        // A high "start" bit is line noise or a stray edge.
                        if (!r_data_s2) begin
                            r_state   <= DATA;
                            r_bit_cnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        r_shift   <= {r_data_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= PARITY;
                        end
                    end
                    PARITY: begin
                        r_par_ok <= ^{r_shift, r_data_s2};
                        r_state  <= STOP;
                    end
                    STOP: begin
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end else if (w_timeout) begin
                r_state <= IDLE;
            end
        end
    end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// Turns PS/2 make/break traffic into the scan code of the currently held key
// for the note lookup stage.
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   ps2_clk      : PS/2 clock line (asynchronous, idle high)
//   ps2_data     : PS/2 data line (asynchronous, idle high)
//   scan_code    : make code of the held key, 8'h00 when none
//   key_valid    : high while scan_code is non-zero
//   rx_byte      : last correctly received byte
//   code_strobe  : one-cycle pulse when rx_byte updates
//   frame_err    : one-cycle pulse on parity, stop or timeout error
// All outputs are registered and update the cycle after the stop-bit fall
// event. Extended (E0-prefixed) keys never play.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       key_valid,
    output logic [7:0] rx_byte,
    output logic       code_strobe,
    output logic       frame_err
);

    logic [7:0] w_byte;
    logic       w_strobe;
    logic       w_err;

    logic [7:0] r_scan;
    logic       r_valid;
    logic [7:0] r_rx_byte;
    logic       r_strobe;
    logic       r_err;
    logic       r_break;
    logic       r_ext;

    ps2_frame_rx #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ps2_clk  (ps2_clk),
        .i_ps2_data (ps2_data),
        .o_byte     (w_byte),
        .o_strobe   (w_strobe),
        .o_err      (w_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_scan    <= 8'h00;
            r_valid   <= 1'b0;
            r_rx_byte <= 8'h00;
            r_strobe  <= 1'b0;
            r_err     <= 1'b0;
            r_break   <= 1'b0;
            r_ext     <= 1'b0;
        end else begin
            r_strobe <= w_strobe;
            r_err    <= w_err;
            if (w_strobe) begin
                r_rx_byte <= w_byte;
                if (w_byte == PS2_BREAK) begin
                    r_break <= 1'b1;
                end else if (w_byte == PS2_EXT) begin
                    r_ext <= 1'b1;
                end else if (is_ignored(w_byte)) begin
                    // Status bytes leave pending prefixes armed.
                    r_break <= r_break;
                end else if (r_ext) begin
                    // Extended make or break: drop it and forget both prefixes.
                    r_ext   <= 1'b0;
                    r_break <= 1'b0;
                end else if (r_break) begin
                    // Releasing a key that is no longer the held one is a no-op.
                    r_break <= 1'b0;
                    if (w_byte == r_scan) begin
                        r_scan  <= 8'h00;
                        r_valid <= 1'b0;
                    end
                end else begin
                    // Last press wins; typematic repeats reload the same code.
                    r_scan  <= w_byte;
                    r_valid <= 1'b1;
                end
            end
        end
    end

    assign scan_code   = r_scan;
    assign key_valid   = r_valid;
    assign rx_byte     = r_rx_byte;
    assign code_strobe = r_strobe;
    assign frame_err   = r_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder. The PS/2 device model runs a scaled bit
// period (2*HALF clk cycles) and the timeout is shortened so the run stays short.
module tb_ps2_key_decoder;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 400;
    localparam int HALF       = 40;
    // Pin fall to fall-event cycle: 2 synchronizer stages + filter depth.
    localparam int FALL_LAT   = 2 + FILTER_LEN;

    logic       clk;
    logic       rst;
    logic       ps2_clk;
    logic       ps2_data;
    logic [7:0] scan_code;
    logic       key_valid;
    logic [7:0] rx_byte;
    logic       code_strobe;
    logic       frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int strobe_cnt = 0;
    int err_cnt    = 0;
    int strobe_cyc = 0;
    int err_cyc    = 0;
    int fall_cyc   = 0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_b;

    ps2_key_decoder #(
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .scan_code   (scan_code),
        .key_valid   (key_valid),
        .rx_byte     (rx_byte),
        .code_strobe (code_strobe),
        .frame_err   (frame_err)
    );

    // Clock / cycle counter
    initial clk = 1'b0;
    always #10 clk = ~clk;
    always @(posedge clk) cyc++;

    // Scoreboard: every strobe must carry the next expected byte.
    always @(negedge clk) begin
        if (code_strobe) begin
            strobe_cnt++;
            strobe_cyc = cyc;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL strobe_unexpected rx_byte=%h expected none", rx_byte);
            end else begin
                exp_b = exp_q.pop_front();
                if (rx_byte !== exp_b) begin
                    n_fail++;
                    $display("FAIL strobe_byte got=%h want=%h", rx_byte, exp_b);
                end
            end
        end
        if (frame_err) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    // Driver tasks
    task automatic send_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (HALF) @(negedge clk);
        ps2_clk  = 1'b0;
        fall_cyc = cyc;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        if (!bad_par && !bad_stop) exp_q.push_back(b);
        for (int i = 0; i < 11; i++) send_bit(f[i]);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    // Tests
    task automatic test_reset;
        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++; if (scan_code !== 8'h00) begin n_fail++; $display("FAIL reset_scan got=%h want=00", scan_code); end
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b want=0", key_valid); end
        n_checks++; if (rx_byte !== 8'h00) begin n_fail++; $display("FAIL reset_rx got=%h want=00", rx_byte); end
        n_checks++; if (strobe_cnt !== 0 || err_cnt !== 0) begin n_fail++; $display("FAIL reset_pulses strobes=%0d errs=%0d want=0,0", strobe_cnt, err_cnt); end
    endtask

    task automatic test_make;
        int s0;
        s0 = strobe_cnt;
        send_frame(8'h1C, 1'b0, 1'b0);
        n_checks++; if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL make_strobes got=%0d want=1", strobe_cnt - s0); end
        n_checks++; if (strobe_cyc - fall_cyc !== FALL_LAT + 1) begin n_fail++; $display("FAIL make_latency got=%0d want=%0d", strobe_cyc - fall_cyc, FALL_LAT + 1); end
        n_checks++; if (rx_byte !== 8'h1C) begin n_fail++; $display("FAIL make_rx got=%h want=1c", rx_byte); end
        n_checks++; if (scan_code !== 8'h1C) begin n_fail++; $display("FAIL make_scan got=%h want=1c", scan_code); end
        n_checks++; if (key_valid !== 1'b1) begin n_fail++; $display("FAIL make_valid got=%b want=1", key_valid); end
    endtask

    task automatic test_break;
        int s0;
        s0 = strobe_cnt;
        send_frame(8'hF0, 1'b0, 1'b0);
        n_checks++; if (scan_code !== 8'h1C) begin n_fail++; $display("FAIL break_prefix_scan got=%h want=1c", scan_code); end
        send_frame(8'h1C, 1'b0, 1'b0);
        n_checks++; if (strobe_cnt - s0 !== 2) begin n_fail++; $display("FAIL break_strobes got=%0d want=2", strobe_cnt - s0); end
        n_checks++; if (scan_code !== 8'h00) begin n_fail++; $display("FAIL break_scan got=%h want=00", scan_code); end
        n_checks++; if (key_valid !== 1'b0) begin n_fail++; $display("FAIL break_valid got=%b want=0", key_valid); end
    endtask

    task automatic test_overlap;
        send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'h2B, 1'b0, 1'b0);
        n_checks++; if (scan_code !== 8'h2B) begin n_fail++; $display("FAIL overlap_last_wins got=%h want=2b", scan_code); end
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h1C, 1'b0, 1'b0);
        n_checks++; if (scan_code !== 8'h2B) begin n_fail++; $display("FAIL overlap_other_release got=%h want=2b", scan_code); end
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h2B, 1'b0, 1'b0);
        n_checks++; if (scan_code !== 8'h00 || key_valid !== 1'b0) begin n_fail++; $display("FAIL overlap_release got=%h/%b want=00/0", scan_code, key_valid); end
    endtask

    task automatic test_errors;
        int s0, e0;
        send_frame(8'h1C, 1'b0, 1'b0);
        s0 = strobe_cnt; e0 = err_cnt;
        send_frame(8'h34, 1'b1, 1'b0);
        send_frame(8'h42, 1'b0, 1'b1);
        n_checks++; if (err_cnt - e0 !== 2) begin n_fail++; $display("FAIL err_count got=%0d want=2", err_cnt - e0); end
        n_checks++; if (err_cyc - fall_cyc !== FALL_LAT + 1) begin n_fail++; $display("FAIL err_latency got=%0d want=%0d", err_cyc - fall_cyc, FALL_LAT + 1); end
        n_checks++; if (strobe_cnt - s0 !== 0) begin n_fail++; $display("FAIL err_no_strobe got=%0d want=0", strobe_cnt - s0); end
        n_checks++; if (scan_code !== 8'h1C || rx_byte !== 8'h1C) begin n_fail++; $display("FAIL err_hold got=%h/%h want=1c/1c", scan_code, rx_byte); end
    endtask

    task automatic test_timeout;
        int s0, e0;
        s0 = strobe_cnt; e0 = err_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (TIMEOUT + 50) @(negedge clk);
        n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL timeout_count got=%0d want=1", err_cnt - e0); end
        n_checks++; if (err_cyc - fall_cyc !== FALL_LAT + TIMEOUT - 1) begin n_fail++; $display("FAIL timeout_latency got=%0d want=%0d", err_cyc - fall_cyc, FALL_LAT + TIMEOUT - 1); end
        n_checks++; if (strobe_cnt - s0 !== 0) begin n_fail++; $display("FAIL timeout_no_strobe got=%0d want=0", strobe_cnt - s0); end
        e0 = err_cnt;
        send_frame(8'h42, 1'b0, 1'b0);
        n_checks++; if (rx_byte !== 8'h42 || scan_code !== 8'h42 || err_cnt !== e0) begin n_fail++; $display("FAIL timeout_recover got=%h/%h errs=%0d want=42/42 errs=%0d", rx_byte, scan_code, err_cnt, e0); end
    endtask

    task automatic test_extended;
        send_frame(8'h4B, 1'b0, 1'b0);
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        n_checks++; if (scan_code !== 8'h4B || rx_byte !== 8'h75) begin n_fail++; $display("FAIL ext_make got=%h/%h want=4b/75", scan_code, rx_byte); end
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b0, 1'b0);
        n_checks++; if (scan_code !== 8'h4B || key_valid !== 1'b1) begin n_fail++; $display("FAIL ext_break got=%h/%b want=4b/1", scan_code, key_valid); end
    endtask

    task automatic test_glitch;
        int s0, e0;
        s0 = strobe_cnt; e0 = err_cnt;
        @(negedge clk);
        ps2_data = 1'b0;
        ps2_clk  = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        ps2_data = 1'b1;
        repeat (30) @(negedge clk);
        send_frame(8'h29, 1'b0, 1'b0);
        n_checks++; if (err_cnt - e0 !== 0 || strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL glitch_pulses errs=%0d strobes=%0d want=0,1", err_cnt - e0, strobe_cnt - s0); end
        n_checks++; if (scan_code !== 8'h29) begin n_fail++; $display("FAIL glitch_scan got=%h want=29", scan_code); end
    endtask

    task automatic test_reset_mid_frame;
        logic [10:0] f;
        f = {1'b1, ~^8'h5A, 8'h5A, 1'b0};
        for (int i = 0; i < 5; i++) send_bit(f[i]);
        repeat (5) @(negedge clk);
        n_checks++; if (scan_code !== 8'h29) begin n_fail++; $display("FAIL mid_pre_scan got=%h want=29", scan_code); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (scan_code !== 8'h00 || key_valid !== 1'b0 || rx_byte !== 8'h00 || code_strobe !== 1'b0 || frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset got=%h/%b/%h/%b/%b want=00/0/00/0/0", scan_code, key_valid, rx_byte, code_strobe, frame_err);
        end
        rst = 1'b0;
        for (int i = 5; i < 11; i++) send_bit(f[i]);
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (2 * TIMEOUT) @(negedge clk);
        send_frame(8'h1C, 1'b0, 1'b0);
        n_checks++; if (scan_code !== 8'h1C || key_valid !== 1'b1) begin n_fail++; $display("FAIL mid_recover got=%h/%b want=1c/1", scan_code, key_valid); end
    endtask

    task automatic test_drain;
        n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL drain_missing got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_make();
        test_break();
        test_overlap();
        test_errors();
        test_timeout();
        test_extended();
        test_glitch();
        test_reset_mid_frame();
        test_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
